// File: rtl/md_unit_if.sv
// Handshake/bus bundle for the md_unit multiply/divide unit.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic                 annul;
  logic                 busy;
  logic                 stallreq;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div_by_zero;

  modport master (
    output start, op, opa, opb, annul,
    input  busy, stallreq, done, result, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb, annul,
    output busy, stallreq, done, result, div_by_zero
  );
endinterface

// File: rtl/md_unit.sv
// Iterative radix-2 multiply/divide unit (multu/mult/divu/div), IDLE->CALC->FIX->DONE.
// Optional macro MD_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  md_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or {remainder, quotient}
  logic [2*WIDTH-1:0]   mc_q, mc_d;        // shifted multiplicand, or divisor in low half
  logic [WIDTH-1:0]     mp_q, mp_d;        // unprocessed multiplier bits
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d; // product / quotient sign
  logic                 neg_hi_q, neg_hi_d; // remainder sign
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dbz_q, dbz_d;

  logic                 a_neg, b_neg, last;
  logic [WIDTH-1:0]     a_mag, b_mag, quo, rem;
  logic [WIDTH:0]       rem_sh, diff;

  always_comb begin
    a_neg  = bus.op[0] & bus.opa[WIDTH-1];
    b_neg  = bus.op[0] & bus.opb[WIDTH-1];
    a_mag  = a_neg ? -bus.opa : bus.opa;
    b_mag  = b_neg ? -bus.opb : bus.opb;
    // Restoring step: borrow out of the (W+1)-bit subtract rejects the quotient bit
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, mc_q[WIDTH-1:0]};
    quo    = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    last     = 1'b0;
    if (bus.annul) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          is_div_d = bus.op[1];
          if (bus.op[1] && bus.opb == '0) begin
            result_d = {bus.opa, {WIDTH{1'b1}}};
            dbz_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
            cnt_d    = '0;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            mp_d     = b_mag;
            if (bus.op[1]) begin
              acc_d = {{WIDTH{1'b0}}, a_mag};
              mc_d  = {{WIDTH{1'b0}}, b_mag};
            end else begin
              acc_d = '0;
              mc_d  = {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
        S_CALC: begin
          cnt_d = cnt_q + CW'(1);
          if (is_div_q) begin
            acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = acc_q + (mp_q[0] ? mc_q : '0);
            mc_d  = mc_q << 1;
            mp_d  = mp_q >> 1;
          end
          last = (cnt_q == CW'(WIDTH-1));
`ifdef MD_EARLY_OUT_EN
          if (!is_div_q && (mp_q >> 1) == '0) last = 1'b1;
`else
          last = last | 1'b0;
`endif
          if (last) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = is_div_q ? {rem, quo} : (neg_lo_q ? -acc_q : acc_q);
          dbz_d    = 1'b0;
          state_d  = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // Status outputs are forced low while reset is held, whatever the state register says
  assign bus.busy        = ~rst & (state_q == S_CALC || state_q == S_FIX);
  assign bus.done        = ~rst & (state_q == S_DONE);
  assign bus.stallreq    = ~rst & ((bus.start & (state_q == S_IDLE) & ~bus.annul) |
                                   (state_q == S_CALC) | (state_q == S_FIX));
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (WIDTH=32), immediate assertions per check.
module tb_md_unit;
  localparam int W = 32;
`ifdef MD_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(W)) bus ();
  md_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; operands become junk afterwards.
  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op = o; bus.opa = a; bus.opb = b; bus.start = 1'b1;
    #1;
    chk("stall_on_start", 64'(bus.stallreq), 64'd1);
    tick();
    bus.start = 1'b0; bus.opa = $urandom; bus.opb = $urandom;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 1;
    while (bus.done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  // Multiply latency: k+2 with early-out (k = bit length of |opb|, min 1), else W+2.
  function automatic int mlat(input int k);
    return EO ? k + 2 : W + 2;
  endfunction

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] er, input logic ed, input int el);
    int cnt;
    go(o, a, b);
    if (el > 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(cnt);
    chk({tag, "_lat"}, 64'(cnt), 64'(el));
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
    chk({tag, "_nostall"}, 64'(bus.stallreq), 64'd0);
    tick();
    chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b1; bus.annul = 1'b0; bus.op = 2'b00;
    bus.opa = 32'd3; bus.opb = 32'd4;
    #1;
    chk("rst_stall", 64'(bus.stallreq), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    tick(); tick();
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0; bus.start = 1'b0;
    tick();
    chk("idle_busy", 64'(bus.busy), 64'd0);

    run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, mlat(32));
    run("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, mlat(3));
    run("mult_7xm3", 2'b01, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, mlat(2));
    run("mult_m5xm6", 2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'd30, 1'b0, mlat(3));
    run("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, mlat(32));
    run("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34);
    run("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 34);
    run("div_mindm1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 34);
    run("divu_100d7", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 34);
    run("divu_by0", 2'b10, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, 1);

    // Annul in the 10th CALC cycle
    go(2'b10, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    chk("pre_annul_busy", 64'(bus.busy), 64'd1);
    bus.annul = 1'b1;
    tick();
    bus.annul = 1'b0;
    chk("annul_busy", 64'(bus.busy), 64'd0);
    chk("annul_done", 64'(bus.done), 64'd0);
    chk("annul_result", bus.result, 64'h0000_0005_FFFF_FFFF);
    chk("annul_dbz", 64'(bus.div_by_zero), 64'd1);
    run("after_annul", 2'b10, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 1'b0, 34);

    // annul wins over start in IDLE
    bus.start = 1'b1; bus.annul = 1'b1; bus.op = 2'b00; bus.opa = 32'd9; bus.opb = 32'd9;
    #1;
    chk("annul_start_stall", 64'(bus.stallreq), 64'd0);
    tick();
    bus.start = 1'b0; bus.annul = 1'b0;
    chk("annul_start_busy", 64'(bus.busy), 64'd0);

    // start held through DONE is taken in the following IDLE cycle
    bus.op = 2'b00; bus.opa = 32'd2; bus.opb = 32'd3; bus.start = 1'b1;
    tick();
    bus.opa = 32'd6; bus.opb = 32'd7;
    wait_done(n);
    chk("hold1_lat", 64'(n), 64'(mlat(2)));
    chk("hold1_res", bus.result, 64'd6);
    chk("hold1_nostall", 64'(bus.stallreq), 64'd0);
    tick();
    chk("hold_idle_busy", 64'(bus.busy), 64'd0);
    chk("hold_idle_stall", 64'(bus.stallreq), 64'd1);
    tick();
    bus.start = 1'b0;
    chk("hold2_busy", 64'(bus.busy), 64'd1);
    wait_done(n);
    chk("hold2_lat", 64'(n), 64'(mlat(3)));
    chk("hold2_res", bus.result, 64'd42);
    tick();

    run("early_out", 2'b00, 32'h1234, 32'd1, 64'h0000_0000_0000_1234, 1'b0, mlat(1));
    run("divu_9by0", 2'b10, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 1'b1, 1);

    // Reset in the middle of CALC
    go(2'b10, 32'd1000, 32'd3);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_stall", 64'(bus.stallreq), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    tick();
    chk("postrst_busy", 64'(bus.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (even, >=8).
REQ-002 SHALL have port clk  in  1  clock, all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  in  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
REQ-006 SHALL have port opa  in  WIDTH  multiplicand or dividend; sampled with start.
REQ-007 SHALL have port opb  in  WIDTH  multiplier or divisor; sampled with start.
REQ-008 SHALL have port annul  in  1  abort the current operation (flush).
REQ-009 SHALL have port busy  out  1  high in CALC and FIX.
REQ-010 SHALL have port stallreq  out  1  = (start & IDLE & ~annul) | CALC | FIX; combinational, drives the pipeline stall.
REQ-011 SHALL have port done  out  1  one-cycle pulse, high only in DONE.
REQ-012 SHALL have port result  out  2*WIDTH  {hi,lo}: product for mult/multu; {remainder,quotient} for div/divu.
REQ-013 SHALL have port div_by_zero  out  1  valid with done; set when a divide had opb==0.

Function
REQ-014 SHALL implement FSM IDLE->CALC->FIX->DONE->IDLE.
REQ-015 IDLE: start=1 at edge N latches operands as magnitudes plus sign flags (signed ops only) and enters CALC; opa/opb are don't-care afterwards.
REQ-016 CALC: one radix-2 iteration per edge (shift-add multiply, restoring divide), exactly WIDTH iterations, then FIX.
REQ-017 FIX: one edge; applies two's-complement sign correction and loads result; enters DONE.
REQ-018 Latency: start at edge N -> DONE entered at edge N+WIDTH+2; IDLE again at edge N+WIDTH+3.
REQ-019 Signed multiply: product sign = sign(opa) XOR sign(opb), full 2*WIDTH bits.
REQ-020 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-021 Most-negative / -1: quotient = most-negative value, remainder = 0; no flag.
REQ-022 Divide with opb==0: IDLE -> DONE at edge N+1 (no CALC/FIX); result = {opa, all ones}; div_by_zero=1.
REQ-023 result and div_by_zero SHALL change only on entry to DONE and hold until the next completed operation.
REQ-024 start is ignored outside IDLE; a start held high during DONE is accepted on the following IDLE cycle.
REQ-025 annul=1 at any edge: next state IDLE; result and div_by_zero unchanged; no done pulse; annul has priority over start.
REQ-026 In DONE, stallreq SHALL be 0 so the issuing instruction retires that cycle.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, result=0, div_by_zero=0, all internal working registers 0, including mid-operation.
REQ-028 While in reset: busy=0, done=0, stallreq=0 (regardless of start).

Configuration
REQ-029 Macro MD_EARLY_OUT_EN: when defined, a multiply SHALL leave CALC after the iteration in which the remaining unprocessed multiplier magnitude bits become zero (minimum 1 iteration); DONE is entered at edge N+k+2, where k = max(1, bit length of |opb|).
REQ-030 Without MD_EARLY_OUT_EN: all multiplies take exactly WIDTH iterations; divides are unaffected in both builds.

Verification (WIDTH=32)
REQ-031 multu 0xFFFFFFFF*0xFFFFFFFF, start at edge N -> done at edge N+34, result 0xFFFFFFFE_00000001; stallreq high from the start cycle through FIX.
REQ-032 mult opa=-3, opb=7 -> result 0xFFFFFFFF_FFFFFFEB, div_by_zero=0.
REQ-033 div opa=-7, opb=2 -> result {0xFFFFFFFF, 0xFFFFFFFD}; div opa=0x80000000, opb=-1 -> {0x00000000, 0x80000000}.
REQ-034 divu opa=5, opb=0 -> DONE at edge N+1, result {0x00000005, 0xFFFFFFFF}, div_by_zero=1.
REQ-035 annul in the 10th CALC cycle -> IDLE at the next edge, no done, result keeps its prior value; a new start on the next cycle completes normally; rst asserted mid-CALC -> all outputs 0 at the next edge.
REQ-036 With MD_EARLY_OUT_EN: multu 0x1234*1 -> DONE at edge N+3, result 0x00000000_00001234; without the macro -> DONE at edge N+34.
